// File: rtl/apb_mem_slave_pkg.sv
// ============================================================================
// apb_mem_slave_pkg : shared types and helpers for the APB4 memory slave
// Rev 1.0
// ============================================================================
`default_nettype none

package apb_mem_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Failing check of the last transfer, ordered by priority
  typedef enum logic [2:0] {
    ERR_NONE  = 3'd0,
    ERR_RANGE = 3'd1,
    ERR_ALIGN = 3'd2,
    ERR_PROT  = 3'd3,
    ERR_RO    = 3'd4
  } err_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/apb_mem_slave_if.sv
// ============================================================================
// apb_mem_slave_if : APB4 bus bundle; PPROT exists only with APB_SLV_PROT_CHECK_EN
// Rev 1.0
// ============================================================================
`default_nettype none

interface apb_mem_slave_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);

  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH-1:0]   PRDATA;
  logic                    PREADY;
  logic                    PSLVERR;
`ifdef APB_SLV_PROT_CHECK_EN
  logic [2:0]              PPROT;
`endif

  modport master (
`ifdef APB_SLV_PROT_CHECK_EN
    output PPROT,
`endif
    output PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
`ifdef APB_SLV_PROT_CHECK_EN
    input  PPROT,
`endif
    input  PSEL, PENABLE, PWRITE, PADDR, PSTRB, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

`default_nettype wire

// File: rtl/apb_strb_mask.sv
// ============================================================================
// apb_strb_mask : expands byte strobes into a per-bit write mask
// Rev 1.0
// ============================================================================
`default_nettype none

module apb_strb_mask
  import apb_mem_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [strb_width(DATA_WIDTH)-1:0] strb_i,
  output logic [DATA_WIDTH-1:0]             mask_o
);

  localparam int STRB_W = strb_width(DATA_WIDTH);

  for (genvar k = 0; k < STRB_W; k++) begin : g_lane
    assign mask_o[8*k +: 8] = {8{strb_i[k]}};
  end

endmodule

`default_nettype wire

// File: rtl/apb_mem_slave.sv
// ============================================================================
// apb_mem_slave : APB4 RAM slave with wait states, RO region and abort handling.
// Optional secure-region check enabled by defining APB_SLV_PROT_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module apb_mem_slave
  import apb_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2,
  parameter int RO_BASE     = 192,
  parameter int SECURE_BASE = 224
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_mem_slave_if.slave   apb
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int OFFS   = $clog2(STRB_W);
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << OFFS) - 1);
  localparam logic [ADDR_WIDTH:0]   IDX_DEPTH  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0]   IDX_RO     = (ADDR_WIDTH+1)'(RO_BASE);
  // The IDLE cycle itself counts as the first wait cycle
  localparam logic [3:0]            WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

  logic                  sel_en;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [ADDR_WIDTH:0]   word_idx_x;
  logic [MEM_AW-1:0]     mem_addr;
  err_e                  err_cause;
  logic                  op_err;
  logic                  do_op;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] bit_mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign sel_en     = apb.PSEL & apb.PENABLE;
  assign word_idx   = apb.PADDR >> OFFS;
  assign word_idx_x = {1'b0, word_idx};
  assign mem_addr   = word_idx[MEM_AW-1:0];

`ifdef APB_SLV_PROT_CHECK_EN
  localparam logic [ADDR_WIDTH:0] IDX_SEC = (ADDR_WIDTH+1)'(SECURE_BASE);
  logic unused_prot;
  assign unused_prot = apb.PPROT[0] ^ apb.PPROT[2];
`else
  logic unused_secure_base;
  assign unused_secure_base = (SECURE_BASE != 0);
`endif

  always_comb begin
    err_cause = ERR_NONE;
    if (word_idx_x >= IDX_DEPTH) begin
      err_cause = ERR_RANGE;
    end else if ((apb.PADDR & ALIGN_MASK) != '0) begin
      err_cause = ERR_ALIGN;
`ifdef APB_SLV_PROT_CHECK_EN
    end else if (apb.PPROT[1] && (word_idx_x >= IDX_SEC)) begin
      err_cause = ERR_PROT;
`endif
    end else if (apb.PWRITE && (word_idx_x >= IDX_RO)) begin
      err_cause = ERR_RO;
    end
  end

  assign op_err = (err_cause != ERR_NONE);

  // Operation fires on the last wait cycle; with no wait states that is the IDLE cycle
  assign do_op = sel_en && (((state_q == IDLE) && (WAIT_STATES == 0)) ||
                            ((state_q == WAIT) && (cnt_q == 4'd0)));
  assign wr_en = do_op && apb.PWRITE && !op_err && PRESETn;

  apb_strb_mask #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strb_mask (
    .strb_i (apb.PSTRB),
    .mask_o (bit_mask)
  );

  assign rd_word  = mem_q[mem_addr];
  assign wr_word  = (rd_word & ~bit_mask) | (apb.PWDATA & bit_mask);
  assign rsp_data = op_err ? '0 : (apb.PWRITE ? prdata_q : rd_word);

  always_ff @(posedge PCLK) begin
    if (wr_en) begin
      mem_q[mem_addr] <= wr_word;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else if (do_op) begin
      state_q   <= RESP;
      pready_q  <= 1'b1;
      pslverr_q <= op_err;
      prdata_q  <= rsp_data;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_en) begin
            state_q <= WAIT;
            cnt_q   <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (!sel_en) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q   <= IDLE;
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign apb.PRDATA  = prdata_q;
  assign apb.PREADY  = pready_q;
  assign apb.PSLVERR = pslverr_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_mem_slave.sv
// ============================================================================
// tb_apb_mem_slave : vector table, directed corner cases and random traffic
// against a word/byte-level memory model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_apb_mem_slave;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int WS = 2;

  logic PCLK    = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus  ();
  apb_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();

  apb_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
    .WAIT_STATES(WS), .RO_BASE(192), .SECURE_BASE(224)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus.slave)
  );

  apb_mem_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256),
    .WAIT_STATES(0), .RO_BASE(192), .SECURE_BASE(224)
  ) dut0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0.slave)
  );

  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [3:0]    pstrb;
  logic [31:0]   pwdata;
  logic          use0;
  logic          prot_ns;

  assign bus.PSEL     = psel & ~use0;
  assign bus0.PSEL    = psel & use0;
  assign bus.PENABLE  = penable;
  assign bus0.PENABLE = penable;
  assign bus.PWRITE   = pwrite;
  assign bus0.PWRITE  = pwrite;
  assign bus.PADDR    = paddr;
  assign bus0.PADDR   = paddr;
  assign bus.PSTRB    = pstrb;
  assign bus0.PSTRB   = pstrb;
  assign bus.PWDATA   = pwdata;
  assign bus0.PWDATA  = pwdata;
`ifdef APB_SLV_PROT_CHECK_EN
  assign bus.PPROT    = {1'b0, prot_ns, 1'b0};
  assign bus0.PPROT   = {1'b0, prot_ns, 1'b0};
`endif

  logic        pready, pslverr;
  logic [31:0] prdata;
  assign pready  = use0 ? bus0.PREADY  : bus.PREADY;
  assign pslverr = use0 ? bus0.PSLVERR : bus.PSLVERR;
  assign prdata  = use0 ? bus0.PRDATA  : bus.PRDATA;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: bytes written so far plus a known-byte mask (RAM is not reset)
  logic [31:0] m_mem [256];
  logic [31:0] m_kn  [256];
  logic [31:0] m_prd;
  logic [31:0] m_prd_kn;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic m_err(input logic wr, input logic [AW-1:0] a);
    int idx;
    idx = int'(a) / 4;
    if (idx >= 256)              return 1'b1;
    if ((int'(a) % 4) != 0)      return 1'b1;
    if (prot_ns && idx >= 224)   return 1'b1;
    if (wr && idx >= 192)        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_commit(input logic wr, input logic [AW-1:0] a,
                                   input logic [31:0] wd, input logic [3:0] st,
                                   input logic e);
    int idx;
    idx = int'(a) / 4;
    if (e) begin
      m_prd    = 32'h0;
      m_prd_kn = 32'hFFFF_FFFF;
    end else if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (st[b]) begin
          m_mem[idx][8*b +: 8] = wd[8*b +: 8];
          m_kn[idx][8*b +: 8]  = 8'hFF;
        end
      end
    end else begin
      m_prd    = m_mem[idx];
      m_prd_kn = m_kn[idx];
    end
  endfunction

  // One complete transfer starting at posedge+1; returns at posedge+1 after RESP
  task automatic run(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd, output logic err);
    int   k;
    logic done;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge PCLK); #1;
    penable = 1'b1;
    k = 0; done = 1'b0; rd = '0; err = 1'b0;
    while (!done && k < 40) begin
      @(negedge PCLK);
      if (pready) begin
        done = 1'b1;
        rd   = prdata;
        err  = pslverr;
      end else begin
        @(posedge PCLK); #1;
        k++;
      end
    end
    if (done) chk("latency", 64'(k), 64'(use0 ? 1 : WS + 1));
    else      chk("pready_timeout", 64'(done), 64'(1));
    @(posedge PCLK); #1;
    psel = 1'b0; penable = 1'b0;
    chk("pready_drop", 64'({pready, pslverr}), 64'(0));
  endtask

  task automatic mchk(input logic wr, input logic [AW-1:0] a, input logic [31:0] wd,
                      input logic [3:0] st);
    logic [31:0] rd, exp, kn;
    logic        err, e;
    int          idx;
    idx = int'(a) / 4;
    e   = m_err(wr, a);
    if (e)       begin exp = 32'h0;      kn = 32'hFFFF_FFFF; end
    else if (!wr) begin exp = m_mem[idx]; kn = m_kn[idx];     end
    else         begin exp = m_prd;      kn = m_prd_kn;      end
    run(wr, a, wd, st, rd, err);
    chk($sformatf("model_pslverr@%03h", a), 64'(err), 64'(e));
    chk($sformatf("model_prdata@%03h", a), 64'(rd & kn), 64'(exp & kn));
    m_commit(wr, a, wd, st, e);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    strb;
    logic [31:0]   exp_rd;
    logic          exp_err;
    logic          chk_rd;
  } vec_t;

  vec_t tv [18];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] rd;
    logic        err;
    int          seen;

    psel = 0; penable = 0; pwrite = 0; paddr = '0; pstrb = '0; pwdata = '0;
    use0 = 0; prot_ns = 0;
    for (int i = 0; i < 256; i++) begin m_mem[i] = '0; m_kn[i] = '0; end
    m_prd = '0; m_prd_kn = 32'hFFFF_FFFF;

    tv[0]  = '{1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b1};
    tv[1]  = '{1'b0, 12'h010, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[2]  = '{1'b1, 12'h020, 32'h11223344, 4'hF, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[3]  = '{1'b1, 12'h020, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, 1'b0, 1'b1};
    tv[4]  = '{1'b0, 12'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 12'h400, 32'h0,        4'hF, 32'h0,        1'b1, 1'b1};
    tv[6]  = '{1'b1, 12'h000, 32'h01020304, 4'hF, 32'h0,        1'b0, 1'b1};
    tv[7]  = '{1'b1, 12'h002, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1, 1'b1};
    tv[8]  = '{1'b0, 12'h000, 32'h0,        4'hF, 32'h01020304, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 12'h300, 32'h12345678, 4'hF, 32'h0,        1'b1, 1'b1};
    tv[10] = '{1'b1, 12'h2FC, 32'h0BADCAFE, 4'hF, 32'h0,        1'b0, 1'b1};
    tv[11] = '{1'b0, 12'h2FC, 32'h0,        4'hF, 32'h0BADCAFE, 1'b0, 1'b1};
    tv[12] = '{1'b1, 12'h004, 32'h77777777, 4'hF, 32'h0BADCAFE, 1'b0, 1'b1};
    tv[13] = '{1'b1, 12'h004, 32'hFFFFFFFF, 4'h0, 32'h0BADCAFE, 1'b0, 1'b1};
    tv[14] = '{1'b0, 12'h004, 32'h0,        4'hF, 32'h77777777, 1'b0, 1'b1};
    tv[15] = '{1'b0, 12'h3FC, 32'h0,        4'hF, 32'h0,        1'b0, 1'b0};
    tv[16] = '{1'b0, 12'h3FE, 32'h0,        4'hF, 32'h0,        1'b1, 1'b1};
    tv[17] = '{1'b1, 12'hFFC, 32'h5A5A5A5A, 4'hF, 32'h0,        1'b1, 1'b1};

    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_prdata",  64'(prdata),  64'(0));
    chk("reset_pready",  64'(pready),  64'(0));
    chk("reset_pslverr", 64'(pslverr), 64'(0));
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    for (int i = 0; i < 18; i++) begin
      run(tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].strb, rd, err);
      chk($sformatf("vec%0d_pslverr", i), 64'(err), 64'(tv[i].exp_err));
      if (tv[i].chk_rd) chk($sformatf("vec%0d_prdata", i), 64'(rd), 64'(tv[i].exp_rd));
      m_commit(tv[i].wr, tv[i].addr, tv[i].wdata, tv[i].strb, m_err(tv[i].wr, tv[i].addr));
    end

    // Abort: drop the select while the write is waiting
    mchk(1'b1, 12'h008, 32'h55AA55AA, 4'hF);
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h008; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1;
    @(posedge PCLK); #1;
    psel = 0; penable = 0;
    seen = 0;
    for (int c = 0; c < WS + 4; c++) begin
      @(negedge PCLK);
      if (pready) seen++;
    end
    chk("abort_pready_seen", 64'(seen), 64'(0));
    chk("abort_prdata_held", 64'(prdata & m_prd_kn), 64'(m_prd & m_prd_kn));
    @(posedge PCLK); #1;
    mchk(1'b0, 12'h008, 32'h0, 4'hF);

    // Reset in the middle of a waiting write
    mchk(1'b1, 12'h00C, 32'h13572468, 4'hF);
    mchk(1'b0, 12'h00C, 32'h0, 4'hF);
    psel = 1; penable = 0; pwrite = 1; paddr = 12'h00C; pwdata = 32'hFFFF0000; pstrb = 4'hF;
    @(posedge PCLK); #1;
    penable = 1;
    @(posedge PCLK); #2;
    PRESETn = 1'b0;
    #1;
    chk("midwait_reset_outputs", 64'({prdata, pready, pslverr}), 64'(0));
    psel = 0; penable = 0;
    @(posedge PCLK); #1;
    PRESETn  = 1'b1;
    m_prd    = 32'h0;
    m_prd_kn = 32'hFFFF_FFFF;
    @(posedge PCLK); #1;
    mchk(1'b0, 12'h00C, 32'h0, 4'hF);

    for (int n = 0; n < 80; n++) begin
      int       idx, off;
      logic     wr;
      wr  = 1'($urandom_range(0, 1));
      idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(180, 259)) : int'($urandom_range(0, 15));
      off = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
      mchk(wr, AW'(idx * 4 + off), $urandom, 4'($urandom_range(0, 15)));
    end

`ifdef APB_SLV_PROT_CHECK_EN
    prot_ns = 1'b1;
    mchk(1'b1, 12'h398, 32'h600DF00D, 4'hF);
    mchk(1'b0, 12'h320, 32'h0, 4'hF);
    prot_ns = 1'b0;
    mchk(1'b1, 12'h398, 32'h600DF00D, 4'hF);
`endif

    // Zero-wait-state instance: back-to-back write then read
    use0 = 1'b1;
    run(1'b1, 12'h004, 32'hCAFEF00D, 4'hF, rd, err);
    chk("ws0_write_pslverr", 64'(err), 64'(0));
    run(1'b0, 12'h004, 32'h0, 4'hF, rd, err);
    chk("ws0_read_prdata", 64'(rd), 64'(32'hCAFEF00D));
    chk("ws0_read_pslverr", 64'(err), 64'(0));
    run(1'b0, 12'h400, 32'h0, 4'hF, rd, err);
    chk("ws0_range_pslverr", 64'(err), 64'(1));
    chk("ws0_range_prdata", 64'(rd), 64'(0));
    use0 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
